// File: rtl/capture_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : capture_seq_pkg
// Purpose  : Shared definitions for the capture sequencer: FSM state
//            encoding and default bus/address widths.
// Revision : 1.0 - initial release
// ============================================================================
package capture_seq_pkg;

    localparam int BYTE_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_FULL    = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RD_OUT  = 3'd5
    } state_t;

endpackage : capture_seq_pkg
`default_nettype wire

// File: rtl/capture_seq_ts_buf.sv
`default_nettype none
// ============================================================================
// Module   : ts_buf
// Purpose  : Tri-state driver onto a shared bus. Drives din while oe is
//            high, otherwise releases the bus to high-Z.
// Ports    : oe  - output enable
//            din - data to drive
//            bus - shared bidirectional bus
// Revision : 1.0 - initial release
// ============================================================================
module ts_buf
    import capture_seq_pkg::*;
#(
    parameter int WIDTH = BYTE_W_DEF
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0] bus
);

    assign bus = oe ? din : {WIDTH{1'bz}};

endmodule : ts_buf
`default_nettype wire

// File: rtl/capture_seq.sv
`default_nettype none
// ============================================================================
// Module   : capture_seq
// Purpose  : Capture sequencer and sole master of the sample RAM. Writes an
//            incoming valid/ready sample stream to consecutive addresses,
//            then on request reads the samples back in write order as a
//            second valid/ready stream.
// Ports    : clk, rst_n            - clock, async active-low reset
//            mem_bus/addr/re/we    - RAM data bus (inout) and controls
//            arm, stop, dump       - single-cycle control pulses
//            s_data/valid/ready    - sample input stream
//            m_data/valid/ready    - readout stream
//            level                 - number of stored samples
//            busy                  - high outside IDLE and FULL
// Config   : CAPTURE_SEQ_WRAP_EN   - ring mode: FILL runs until stop, write
//                                    pointer wraps at DEPTH, readout starts
//                                    at the oldest sample.
// Revision : 1.0 - initial release
// ============================================================================
module capture_seq
    import capture_seq_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [BYTE_W-1:0] mem_bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    input  logic              arm,
    input  logic              stop,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              dump,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   level,
    output logic              busy
);

    localparam logic [ADDR_W:0] DEPTH_LV = (ADDR_W+1)'(DEPTH);
`ifdef CAPTURE_SEQ_WRAP_EN
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
`else
    localparam logic [ADDR_W:0] DEPTH_M1_LV = (ADDR_W+1)'(DEPTH - 1);
`endif

    state_t              state_q,  state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     level_q,  level_d;
    logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
    logic [BYTE_W-1:0]   m_data_q, m_data_d;

    // Pointer advance: ring mode wraps at DEPTH, otherwise natural modulo.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
`ifdef CAPTURE_SEQ_WRAP_EN
        ptr_inc = (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
`else
        ptr_inc = p + ADDR_W'(1);
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rd_cnt_q <= '0;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rd_cnt_q <= rd_cnt_d;
            m_data_q <= m_data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rd_cnt_d = rd_cnt_q;
        m_data_d = m_data_q;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = '0;
        s_ready  = 1'b0;
        m_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    wr_ptr_d = '0;
                    level_d  = '0;
                    state_d  = ST_FILL;
                end
            end

            ST_FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    // RAM samples the bus on the same edge that accepts.
                    mem_we   = 1'b1;
                    mem_addr = wr_ptr_q;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
`ifdef CAPTURE_SEQ_WRAP_EN
                    level_d  = (level_q == DEPTH_LV) ? level_q
                                                     : level_q + (ADDR_W+1)'(1);
`else
                    level_d  = level_q + (ADDR_W+1)'(1);
                    if (level_q == DEPTH_M1_LV) begin
                        state_d = ST_FULL;
                    end
`endif
                end
                if (stop) begin
                    state_d = ST_FULL;
                end
            end

            ST_FULL: begin
                if (dump) begin
                    if (level_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
`ifdef CAPTURE_SEQ_WRAP_EN
                        // After a wrap the oldest sample sits at wr_ptr.
                        rd_ptr_d = (level_q == DEPTH_LV) ? wr_ptr_q : '0;
`else
                        rd_ptr_d = '0;
`endif
                        rd_cnt_d = level_q;
                        state_d  = ST_RD_ADDR;
                    end
                end else if (arm) begin
                    wr_ptr_d = '0;
                    level_d  = '0;
                    state_d  = ST_FILL;
                end
            end

            // The RAM registers read data, so re is held for two cycles:
            // address phase, then data phase while the RAM drives the bus.
            ST_RD_ADDR: begin
                mem_re   = 1'b1;
                mem_addr = rd_ptr_q;
                state_d  = ST_RD_DATA;
            end

            ST_RD_DATA: begin
                mem_re   = 1'b1;
                mem_addr = rd_ptr_q;
                m_data_d = mem_bus;
                state_d  = ST_RD_OUT;
            end

            ST_RD_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                    rd_cnt_d = rd_cnt_q - (ADDR_W+1)'(1);
                    state_d  = (rd_cnt_q == (ADDR_W+1)'(1)) ? ST_FULL : ST_RD_ADDR;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign level  = level_q;
    assign m_data = m_data_q;
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_FULL);

    ts_buf #(
        .WIDTH (BYTE_W)
    ) u_ts_buf (
        .oe    (mem_we),
        .din   (s_data),
        .bus   (mem_bus)
    );

endmodule : capture_seq
`default_nettype wire

// File: tb/tb_capture_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_seq
// Purpose  : Directed self-checking bench for capture_seq with a small
//            registered-read RAM model on the shared bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_seq;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    wire  [BYTE_W-1:0] mem_bus;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic              arm = 1'b0;
    logic              stop = 1'b0;
    logic [BYTE_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              dump = 1'b0;
    logic [BYTE_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [ADDR_W:0]   level;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int re_total = 0;
    logic [BYTE_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    capture_seq #(
        .BYTE_W (BYTE_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_bus  (mem_bus),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .arm      (arm),
        .stop     (stop),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .dump     (dump),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .busy     (busy)
    );

    // RAM model: write on edge; read data registered and driven only while
    // re stays high for a second cycle.
    logic [BYTE_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [BYTE_W-1:0] ram_rd_q = '0;
    logic              ram_re_q = 1'b0;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_bus;
        if (mem_re) ram_rd_q <= ram[mem_addr];
        ram_re_q <= mem_re;
    end

    assign mem_bus = (ram_re_q && mem_re) ? ram_rd_q : {BYTE_W{1'bz}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (mem_re) re_total++;
    end

    always @(negedge clk) begin
        if (rst_n) check("we_re_excl", {31'b0, mem_we & mem_re}, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_capture();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic feed(input logic [BYTE_W-1:0] d, input int addr);
        s_valid = 1'b1;
        s_data  = d;
        #1;
        check("wr_we",   {31'b0, mem_we}, 32'd1);
        check("wr_addr", 32'(mem_addr), 32'(addr));
        check("wr_bus",  32'(mem_bus), 32'(d));
        tick();
        s_valid = 1'b0;
    endtask

    // Dump exp_q; optionally stall m_ready on one sample.
    task automatic readout(input int stall_idx, input int stall_cycles);
        int n;
        int waited;
        int re_start;
        n        = exp_q.size();
        re_start = re_total;
        s_data   = 8'hEE;
        m_ready  = 1'b1;
        dump     = 1'b1;
        tick();
        dump     = 1'b0;
        check("rd_busy", {31'b0, busy}, 32'd1);
        for (int k = 0; k < n; k++) begin
            if (k == stall_idx) m_ready = 1'b0;
            waited = 0;
            while (!m_valid && waited < 20) begin
                tick();
                waited++;
            end
            check("rd_latency", 32'(waited), 32'd2);
            check("rd_data", 32'(m_data), 32'(exp_q[k]));
            if (k == stall_idx) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    tick();
                    check("stall_valid", {31'b0, m_valid}, 32'd1);
                    check("stall_data", 32'(m_data), 32'(exp_q[k]));
                    check("stall_re", {31'b0, mem_re}, 32'd0);
                end
                m_ready = 1'b1;
            end
            tick();
        end
        check("rd_end_valid", {31'b0, m_valid}, 32'd0);
        check("rd_end_busy", {31'b0, busy}, 32'd0);
        check("rd_re_cycles", 32'(re_total - re_start), 32'(2 * n));
    endtask

    task automatic load_four();
        arm_capture();
        check("fill_ready", {31'b0, s_ready}, 32'd1);
        check("fill_busy", {31'b0, busy}, 32'd1);
        feed(8'h11, 0);
        feed(8'h22, 1);
        feed(8'h33, 2);
        feed(8'h44, 3);
        stop_pulse();
        check("four_level", 32'(level), 32'd4);
        check("four_busy", {31'b0, busy}, 32'd0);
        check("four_ready", {31'b0, s_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        // Reset state
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_sready", {31'b0, s_ready}, 32'd0);
        check("rst_mvalid", {31'b0, m_valid}, 32'd0);
        check("rst_mdata", 32'(m_data), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_re_we", {30'b0, mem_re, mem_we}, 32'd0);
        #3 rst_n = 1'b1;
        tick();

        // dump in IDLE is ignored
        dump = 1'b1;
        tick();
        dump = 1'b0;
        check("idle_dump_busy", {31'b0, busy}, 32'd0);

        // Basic capture and readout
        load_four();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        readout(-1, 0);
        check("post_rd_level", 32'(level), 32'd4);

        // Fill to DEPTH with 10 offered samples
        arm_capture();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            #1;
            if (s_ready) acc++;
            tick();
        end
        s_valid = 1'b0;
        exp_q.delete();
`ifdef CAPTURE_SEQ_WRAP_EN
        check("wrap_accepted", 32'(acc), 32'd10);
        check("wrap_level", 32'(level), 32'd8);
        check("wrap_ready", {31'b0, s_ready}, 32'd1);
        stop_pulse();
        for (int i = 2; i < 10; i++) exp_q.push_back(8'(i));
`else
        check("full_accepted", 32'(acc), 32'd8);
        check("full_level", 32'(level), 32'd8);
        check("full_ready", {31'b0, s_ready}, 32'd0);
        check("full_busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
`endif
        readout(-1, 0);

        // Backpressure: stall on the 2nd sample
        load_four();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        readout(1, 5);

        // Reset during RD_DATA
        dump = 1'b1;
        tick();
        dump = 1'b0;
        tick();
        check("pre_rst_re", {31'b0, mem_re}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_re", {31'b0, mem_re}, 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_mdata", 32'(m_data), 32'd0);
        check("mid_rst_mvalid", {31'b0, m_valid}, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        arm_capture();
        feed(8'hA5, 0);
        stop_pulse();
        check("a5_level", 32'(level), 32'd1);
        exp_q = '{8'hA5};
        readout(-1, 0);

        // Empty capture: dump with level 0
        arm_capture();
        stop_pulse();
        check("empty_level", 32'(level), 32'd0);
        check("empty_busy", {31'b0, busy}, 32'd0);
        acc = re_total;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("empty_mvalid", {31'b0, m_valid}, 32'd0);
            check("empty_busy2", {31'b0, busy}, 32'd0);
            tick();
        end
        check("empty_re", 32'(re_total - acc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_capture_seq
`default_nettype wire
